// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one request/response memory bus between the instruction-fetch
// port (I) and the data port (D). Requests are latched into one slot per
// port, granted one at a time, and exactly one transaction is kept
// outstanding on the bus. Responses go back to the owning port; a hung
// bus is recovered by an optional timeout (TIMEOUT = 0 disables it).
// Optional macro ARB_ROUND_ROBIN_EN: on contention the grant alternates
// between the ports instead of D always winning over I.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req_en,
  input  logic [31:0] i_addr,
  output logic        i_resp_en,
  output logic [31:0] i_data,
  input  logic        d_req_en,
  input  logic        d_mode,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_resp_en,
  output logic [31:0] d_data,
  output logic        bus_req_en,
  output logic        bus_mode,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_resp_en,
  input  logic [31:0] bus_data,
  output logic        busy,
  output logic        err,
  output logic        ovf
);

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  // Last counter value spent in WAIT before the transaction is abandoned
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_pend_i;
  logic            r_pend_d;
  logic            r_owner_d;
  logic [TO_W-1:0] r_cnt;

  logic [31:0]     r_i_addr;
  logic            r_d_mode;
  logic [31:0]     r_d_addr;
  logic [31:0]     r_d_wdata;
  logic [3:0]      r_d_wstrb;

  logic            w_grant_d;
  logic            w_timeout;
  logic            w_done;
  logic [31:0]     w_ret_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic            r_rr_d;

  // On contention the pointer decides; a lone pending port always wins
  assign w_grant_d = r_pend_d & (~r_pend_i | r_rr_d);

  // Pointer moves away from the winner after every contended grant
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rr_d <= 1'b1;
    end else if (r_state == IDLE && r_pend_i && r_pend_d) begin
      r_rr_d <= ~w_grant_d;
    end
  end
`else
  // D has fixed priority over I
  assign w_grant_d = r_pend_d;
`endif

  assign w_timeout  = TO_EN && (r_cnt == TO_LAST);
  assign w_done     = bus_resp_en || w_timeout;
  // Timeouts and write responses both return zero data
  assign w_ret_data = (bus_resp_en && bus_mode == MEMREQ_READ) ? bus_data : 32'h0;
  assign busy       = (r_state == WAIT) | r_pend_i | r_pend_d;

  // Request slots: latch a port's fields only when it has nothing pending
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_i_addr  <= '0;
      r_d_mode  <= MEMREQ_READ;
      r_d_addr  <= '0;
      r_d_wdata <= '0;
      r_d_wstrb <= '0;
    end else begin
      if (i_req_en && !r_pend_i) begin
        r_i_addr <= i_addr;
      end
      if (d_req_en && !r_pend_d) begin
        r_d_mode  <= d_mode;
        r_d_addr  <= d_addr;
        r_d_wdata <= d_wdata;
        r_d_wstrb <= d_wstrb;
      end
    end
  end

  // Arbitration FSM: grant a slot, wait for its response or timeout, reply
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_pend_i   <= 1'b0;
      r_pend_d   <= 1'b0;
      r_owner_d  <= 1'b0;
      r_cnt      <= '0;
      bus_req_en <= 1'b0;
      bus_mode   <= MEMREQ_READ;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
      i_resp_en  <= 1'b0;
      i_data     <= '0;
      d_resp_en  <= 1'b0;
      d_data     <= '0;
      err        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      bus_req_en <= 1'b0;
      i_resp_en  <= 1'b0;
      d_resp_en  <= 1'b0;
      err        <= 1'b0;

      if ((i_req_en && r_pend_i) || (d_req_en && r_pend_d)) begin
        ovf <= 1'b1;
      end
      if (i_req_en && !r_pend_i) begin
        r_pend_i <= 1'b1;
      end
      if (d_req_en && !r_pend_d) begin
        r_pend_d <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (r_pend_i || r_pend_d) begin
            r_owner_d  <= w_grant_d;
            r_cnt      <= '0;
            bus_req_en <= 1'b1;
            r_state    <= WAIT;
            if (w_grant_d) begin
              bus_mode  <= r_d_mode;
              bus_addr  <= r_d_addr;
              bus_wdata <= r_d_wdata;
              bus_wstrb <= r_d_wstrb;
            end else begin
              bus_mode  <= MEMREQ_READ;
              bus_addr  <= r_i_addr;
              bus_wdata <= '0;
              bus_wstrb <= '0;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + TO_W'(1);
          if (w_done) begin
            r_state <= IDLE;
            err     <= ~bus_resp_en;
            if (r_owner_d) begin
              d_resp_en <= 1'b1;
              d_data    <= w_ret_data;
              r_pend_d  <= 1'b0;
            end else begin
              i_resp_en <= 1'b1;
              i_data    <= w_ret_data;
              r_pend_i  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed scenarios followed by a randomized run checked against a
// transaction-level reference model. Build with ARB_ROUND_ROBIN_EN to
// exercise the alternating grant.
module tb_mem_bus_arbiter;

  localparam int TB_TIMEOUT = 8;

  logic        clk;
  logic        rstn;
  logic        i_req_en;
  logic [31:0] i_addr;
  logic        i_resp_en;
  logic [31:0] i_data;
  logic        d_req_en;
  logic        d_mode;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_resp_en;
  logic [31:0] d_data;
  logic        bus_req_en;
  logic        bus_mode;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_resp_en;
  logic [31:0] bus_data;
  logic        busy;
  logic        err;
  logic        ovf;

  int assertCount = 0;
  int failCount   = 0;

  mem_bus_arbiter #(
    .TIMEOUT(TB_TIMEOUT),
    .TO_W   (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_req_en   (i_req_en),
    .i_addr     (i_addr),
    .i_resp_en  (i_resp_en),
    .i_data     (i_data),
    .d_req_en   (d_req_en),
    .d_mode     (d_mode),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_wstrb    (d_wstrb),
    .d_resp_en  (d_resp_en),
    .d_data     (d_data),
    .bus_req_en (bus_req_en),
    .bus_mode   (bus_mode),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wstrb  (bus_wstrb),
    .bus_resp_en(bus_resp_en),
    .bus_data   (bus_data),
    .busy       (busy),
    .err        (err),
    .ovf        (ovf)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: one request per port, one bus transaction at a time
  typedef struct {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t        mSlot [2];
  logic [1:0]  mPend;
  logic        mInWait;
  int          mOwner;
  int          mWaited;
`ifdef ARB_ROUND_ROBIN_EN
  logic        mFavD;
`endif
  logic        eBusReq;
  logic        eBusMode;
  logic [31:0] eBusAddr;
  logic [31:0] eBusWdata;
  logic [3:0]  eBusWstrb;
  logic        eIResp;
  logic [31:0] eIData;
  logic        eDResp;
  logic [31:0] eDData;
  logic        eErr;
  logic        eOvf;
  logic        eBusy;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and advance to the next falling edge
  task automatic applyStimulus(input logic iReq, input logic [31:0] iA,
                               input logic dReq, input logic dM, input logic [31:0] dA,
                               input logic [31:0] dW, input logic [3:0] dS,
                               input logic rEn, input logic [31:0] rData);
    i_req_en    = iReq;
    i_addr      = iA;
    d_req_en    = dReq;
    d_mode      = dM;
    d_addr      = dA;
    d_wdata     = dW;
    d_wstrb     = dS;
    bus_resp_en = rEn;
    bus_data    = rData;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  task automatic modelReset();
    for (int p = 0; p < 2; p++) mSlot[p] = '{mode: 1'b0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0};
    mPend = 2'b00; mInWait = 1'b0; mOwner = 0; mWaited = 0;
`ifdef ARB_ROUND_ROBIN_EN
    mFavD = 1'b1;
`endif
    eBusReq = 0; eBusMode = 0; eBusAddr = 0; eBusWdata = 0; eBusWstrb = 0;
    eIResp = 0; eIData = 0; eDResp = 0; eDData = 0; eErr = 0; eOvf = 0; eBusy = 0;
  endtask

  task automatic finishTxn(input logic [31:0] val, input logic timedOut);
    if (mOwner == 0) begin eIResp = 1'b1; eIData = val; end
    else begin eDResp = 1'b1; eDData = val; end
    eErr = timedOut;
    mPend[mOwner] = 1'b0;
    mInWait = 1'b0;
  endtask

  // Advance the model by one cycle using the inputs currently driven
  task automatic modelStep();
    logic [1:0] oldPend;
    int pick;
    oldPend = mPend;
    eIResp = 1'b0; eDResp = 1'b0; eErr = 1'b0; eBusReq = 1'b0;
    if (mInWait) begin
      mWaited++;
      if (bus_resp_en) finishTxn(mSlot[mOwner].mode ? 32'h0 : bus_data, 1'b0);
      else if (TB_TIMEOUT != 0 && mWaited == TB_TIMEOUT) finishTxn(32'h0, 1'b1);
    end else if (oldPend != 2'b00) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (oldPend == 2'b11) begin
        pick  = mFavD ? 1 : 0;
        mFavD = (pick == 0);
      end else pick = oldPend[1] ? 1 : 0;
`else
      pick = oldPend[1] ? 1 : 0;
`endif
      eBusReq   = 1'b1;
      eBusMode  = mSlot[pick].mode;
      eBusAddr  = mSlot[pick].addr;
      eBusWdata = mSlot[pick].wdata;
      eBusWstrb = mSlot[pick].wstrb;
      mOwner    = pick;
      mInWait   = 1'b1;
      mWaited   = 0;
    end
    if (i_req_en) begin
      if (oldPend[0]) eOvf = 1'b1;
      else begin
        mPend[0] = 1'b1;
        mSlot[0] = '{mode: 1'b0, addr: i_addr, wdata: 32'h0, wstrb: 4'h0};
      end
    end
    if (d_req_en) begin
      if (oldPend[1]) eOvf = 1'b1;
      else begin
        mPend[1] = 1'b1;
        mSlot[1] = '{mode: d_mode, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
      end
    end
    eBusy = mInWait || (mPend != 2'b00);
  endtask

  logic        firstIsD;
  logic [31:0] firstAddr;
  logic [31:0] secondAddr;
  int          reqCnt;
  int          respCnt;
  int          respAt;

  // Directed scenarios, then the randomized run against the model
  initial begin
    rstn = 1'b0;
    i_req_en = 0; i_addr = 0; d_req_en = 0; d_mode = 0; d_addr = 0;
    d_wdata = 0; d_wstrb = 0; bus_resp_en = 0; bus_data = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    checkOutput("reset_a", {i_resp_en, i_data, d_resp_en, d_data, busy, err, ovf}, 128'h0);
    checkOutput("reset_b", {bus_req_en, bus_mode, bus_addr, bus_wdata, bus_wstrb}, 128'h0);

    // Single fetch
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    checkOutput("fetch_pending", {busy, bus_req_en}, 2'b10);
    idleCycle();
    checkOutput("fetch_bus", {bus_req_en, bus_mode, bus_addr, bus_wdata, bus_wstrb},
                {1'b1, 1'b0, 32'h100, 32'h0, 4'h0});
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF);
    checkOutput("fetch_resp", {i_resp_en, i_data, d_resp_en, bus_req_en, err},
                {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0});
    idleCycle();
    checkOutput("fetch_hold", {i_resp_en, i_data, busy}, {1'b0, 32'hDEADBEEF, 1'b0});

    // Data write
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011, 1'b0, 32'h0);
    idleCycle();
    checkOutput("write_bus", {bus_req_en, bus_mode, bus_addr, bus_wdata, bus_wstrb},
                {1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011});
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hFFFFFFFF);
    checkOutput("write_resp", {d_resp_en, d_data, i_resp_en, i_data},
                {1'b1, 32'h0, 1'b0, 32'hDEADBEEF});

    // Collision one: D wins in both builds
    applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("coll1_first_bus", {bus_req_en, bus_mode, bus_addr, bus_wstrb},
                {1'b1, 1'b0, 32'h300, 4'h0});
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h11111111);
    checkOutput("coll1_first_resp", {d_resp_en, d_data, i_resp_en, bus_req_en},
                {1'b1, 32'h11111111, 1'b0, 1'b0});
    idleCycle();
    checkOutput("coll1_second_bus", {bus_req_en, bus_mode, bus_addr, bus_wstrb},
                {1'b1, 1'b0, 32'h400, 4'h0});
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h22222222);
    checkOutput("coll1_second_resp", {i_resp_en, i_data, d_resp_en},
                {1'b1, 32'h22222222, 1'b0});

    // Collision two: fixed priority repeats D, round robin switches to I
`ifdef ARB_ROUND_ROBIN_EN
    firstIsD = 1'b0;
`else
    firstIsD = 1'b1;
`endif
    firstAddr  = firstIsD ? 32'h800 : 32'h700;
    secondAddr = firstIsD ? 32'h700 : 32'h800;
    applyStimulus(1'b1, 32'h700, 1'b1, 1'b0, 32'h800, 32'h0, 4'h0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("coll2_first_bus", {bus_req_en, bus_addr}, {1'b1, firstAddr});
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h33333333);
    checkOutput("coll2_first_resp", {i_resp_en, d_resp_en}, {~firstIsD, firstIsD});
    idleCycle();
    checkOutput("coll2_second_bus", {bus_req_en, bus_addr}, {1'b1, secondAddr});
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h44444444);
    checkOutput("coll2_second_resp", {i_resp_en, d_resp_en}, {firstIsD, ~firstIsD});

    // Overflow: second D request while the first is in flight
    checkOutput("ovf_clear", ovf, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("ovf_bus", {bus_req_en, bus_addr}, {1'b1, 32'h500});
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, 4'h0, 1'b0, 32'h0);
    checkOutput("ovf_set", ovf, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hABCD0001);
    checkOutput("ovf_resp", {d_resp_en, d_data}, {1'b1, 32'hABCD0001});
    reqCnt = 0;
    respCnt = 0;
    for (int k = 0; k < 6; k++) begin
      idleCycle();
      reqCnt  += int'(bus_req_en);
      respCnt += int'(d_resp_en);
    end
    checkOutput("ovf_single_txn", {reqCnt, respCnt}, 64'h0);
    checkOutput("ovf_sticky", {ovf, busy}, 2'b10);

    // Timeout: fetch with no bus response
    applyStimulus(1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    idleCycle();
    checkOutput("to_bus", {bus_req_en, bus_addr}, {1'b1, 32'h900});
    for (int k = 1; k <= TB_TIMEOUT; k++) begin
      idleCycle();
      if (k < TB_TIMEOUT) checkOutput("to_quiet", {i_resp_en, err}, 2'b00);
      else checkOutput("to_abort", {i_resp_en, err, i_data}, {1'b1, 1'b1, 32'h0});
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h55555555);
    checkOutput("to_late_resp", {i_resp_en, d_resp_en, err, busy, i_data}, 36'h0);

    // Reset while a data read is in flight, then a stray response
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'hA00, 32'h0, 4'h0, 1'b0, 32'h0);
    idleCycle();
    idleCycle();
    rstn = 1'b0;
    idleCycle();
    rstn = 1'b1;
    checkOutput("rst_wait_a", {i_resp_en, i_data, d_resp_en, d_data, busy, err, ovf}, 128'h0);
    checkOutput("rst_wait_b", {bus_req_en, bus_mode, bus_addr, bus_wdata, bus_wstrb}, 128'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h66666666);
    checkOutput("rst_stray", {i_resp_en, d_resp_en, busy, err, bus_req_en, i_data, d_data}, 69'h0);

    // Randomized traffic against the reference model
    rstn = 1'b0;
    idleCycle();
    rstn = 1'b1;
    modelReset();
    respAt = -1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      checkOutput("rnd_bus", {bus_req_en, bus_mode, bus_addr, bus_wdata, bus_wstrb},
                  {eBusReq, eBusMode, eBusAddr, eBusWdata, eBusWstrb});
      checkOutput("rnd_iport", {i_resp_en, i_data}, {eIResp, eIData});
      checkOutput("rnd_dport", {d_resp_en, d_data}, {eDResp, eDData});
      checkOutput("rnd_status", {busy, err, ovf}, {eBusy, eErr, eOvf});
      if (bus_req_en) respAt = cyc + int'($urandom_range(0, 11));
      bus_resp_en = (cyc == respAt);
      bus_data    = $urandom();
      i_req_en    = ($urandom_range(0, 99) < 20);
      i_addr      = $urandom() & 32'hFFFF_FFFC;
      d_req_en    = ($urandom_range(0, 99) < 20);
      d_mode      = 1'($urandom_range(0, 1));
      d_addr      = $urandom() & 32'hFFFF_FFFC;
      d_wdata     = $urandom();
      d_wstrb     = 4'($urandom_range(0, 15));
      modelStep();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
